prog_counter: RTL

Programmable-modulus up/down counter with start/stop control, three counting modes (wrap, saturate, one-shot) and a registered terminal-count pulse. It is the parametrised successor of the team's fixed-modulus wrap counter. It is used wherever the datapath needs runtime-configurable event counting, timeouts or tick generation. An optional prescaler divides the enable rate before counting.

---
 rtl/prog_counter.sv | 74 +++++++
 1 files changed

// File: rtl/prog_counter.sv
// prog_counter: programmable-modulus up/down counter with wrap, saturate and one-shot modes
// Ports: clk, reset (sync, active-high); enable qualifies ticks; start/stop pulse the RUN state;
//   dir 1=up 0=down; mode 00 wrap, 01 saturate, 10 one-shot, 11 wrap; load/load_value set count;
//   limit is the up terminal and the down restart value; prescale divides enabled cycles.
//   Outputs count, one-cycle tc pulse, busy (RUN), done (one-shot finished); all registered.
// Define PROG_COUNTER_PRESCALE_EN to build in the prescaler; otherwise prescale is unused.
module prog_counter #(
  parameter int WIDTH = 8,
  parameter int PRESCALE_WIDTH = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      start,
  input  logic                      stop,
  input  logic                      dir,
  input  logic [1:0]                mode,
  input  logic                      load,
  input  logic [WIDTH-1:0]          load_value,
  input  logic [WIDTH-1:0]          limit,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  output logic [WIDTH-1:0]          count,
  output logic                      tc,
  output logic                      busy,
  output logic                      done
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic run, go, halt, pmatch, tick, term, hold;
  assign run = state == RUN;
  assign halt = stop && run;
  assign go = start && !stop && !run;
  assign tick = run && enable && !load && !stop && pmatch;
  assign term = dir ? count >= limit : count == '0;
  assign hold = mode == 2'b01 || mode == 2'b10;
`ifdef PROG_COUNTER_PRESCALE_EN
  logic [PRESCALE_WIDTH-1:0] psc;
  assign pmatch = psc == prescale;
  always_ff @(posedge clk) begin
    if (reset || load || stop || go) psc <= '0;
    else if (run && enable) psc <= pmatch ? '0 : psc + 1'b1;
  end
`else
  logic unused_prescale;
  assign unused_prescale = ^prescale;
  assign pmatch = 1'b1;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      count <= '0;
      tc <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      tc <= tick && term;
      if (load || (go && state == DONE)) count <= load_value;
      else if (tick) count <= term ? (hold ? count : (dir ? '0 : limit)) : (dir ? count + 1'b1 : count - 1'b1);
      if (halt || (load && state == DONE && !go)) begin
        state <= IDLE;
        busy <= 1'b0;
        done <= 1'b0;
      end else if (go) begin
        state <= RUN;
        busy <= 1'b1;
        done <= 1'b0;
      end else if (tick && term && mode == 2'b10) begin
        state <= DONE;
        busy <= 1'b0;
        done <= 1'b1;
      end
    end
  end
endmodule
